// File: rtl/alu_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer_pkg
// Brief    : Shared constants, op encodings and FSM state type for the
//            ALU command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_cmd_sequencer_pkg;

  // Operand/result width of the attached ALU.
  localparam int ALU_WIDTH = 8;

  // s2 splits the op space into the arithmetic and the logic group.
  localparam logic OP_GROUP_ARITH = 1'b0;
  localparam logic OP_GROUP_LOGIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // True when the select addresses the logic group.
  function automatic logic op_is_logic(input logic [2:0] op);
    return op[2] == OP_GROUP_LOGIC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer_if
// Brief    : Command stream, ALU drive/return, result stream and status
//            signals of the ALU command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_s2;
  logic             alu_s1;
  logic             alu_s0;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic             alu_v;
  logic             alu_z;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_f;
  logic             res_c;
  logic             res_v;
  logic             res_z;
  logic [2:0]       res_op;

  logic             sticky_v;
  logic             sticky_clr;
  logic             busy;

  // Environment side: offers commands, evaluates the ALU, consumes results.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s2, alu_s1, alu_s0,
    output alu_f, alu_c, alu_v, alu_z,
    input  res_valid, res_f, res_c, res_v, res_z, res_op,
    output res_ready,
    input  sticky_v, busy,
    output sticky_clr
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_s2, alu_s1, alu_s0,
    input  alu_f, alu_c, alu_v, alu_z,
    output res_valid, res_f, res_c, res_v, res_z, res_op,
    input  res_ready,
    output sticky_v, busy,
    input  sticky_clr
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_fifo
// Brief    : Synchronous command FIFO, power-of-two depth, push/pop with
//            full/empty/count status. Overflowing pushes and underflowing
//            pops are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 19
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic [DATA_W-1:0]        din,
  input  wire logic                     pop,
  output logic      [DATA_W-1:0]        dout,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Buffers ALU commands, drives the combinational ALU from
//            registered inputs for one full cycle, captures F/flags and
//            presents them on a valid/ready result stream.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ALU_WIDTH
) (
  input wire logic          clk,
  input wire logic          rst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int DW = 2*WIDTH + 3;

  state_t              r_state;
  logic [WIDTH-1:0]    r_alu_a;
  logic [WIDTH-1:0]    r_alu_b;
  logic [2:0]          r_op;
  logic                r_res_valid;
  logic [WIDTH-1:0]    r_res_f;
  logic                r_res_c;
  logic                r_res_v;
  logic                r_res_z;
  logic [2:0]          r_res_op;
  logic                r_sticky_v;

  logic [DW-1:0]           w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_pop;

  // The FSM is the only consumer: it pops from IDLE, or from HOLD as the
  // current result is handed off.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || (r_state == ST_HOLD && bus.res_ready));

  alu_cmd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .din   ({bus.cmd_op, bus.cmd_b, bus.cmd_a}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign bus.cmd_ready = !w_full;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_s2    = r_op[2];
  assign bus.alu_s1    = r_op[1];
  assign bus.alu_s0    = r_op[0];
  assign bus.res_valid = r_res_valid;
  assign bus.res_f     = r_res_f;
  assign bus.res_c     = r_res_c;
  assign bus.res_v     = r_res_v;
  assign bus.res_z     = r_res_z;
  assign bus.res_op    = r_res_op;
  assign bus.sticky_v  = r_sticky_v;
  assign bus.busy      = (w_count != '0) || (r_state != ST_IDLE);

  // Issue/capture FSM with registered ALU drive, result and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_op        <= '0;
      r_res_valid <= 1'b0;
      r_res_f     <= '0;
      r_res_c     <= 1'b0;
      r_res_v     <= 1'b0;
      r_res_z     <= 1'b0;
      r_res_op    <= '0;
      r_sticky_v  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            {r_op, r_alu_b, r_alu_a} <= w_head;
            r_state                  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_res_f     <= bus.alu_f;
          r_res_c     <= bus.alu_c;
          r_res_v     <= bus.alu_v;
          r_res_z     <= bus.alu_z;
          r_res_op    <= r_op;
          r_res_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              {r_op, r_alu_b, r_alu_a} <= w_head;
              r_state                  <= ST_ISSUE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A fresh overflow capture takes priority over a clear on the same edge.
      if (r_state == ST_ISSUE && bus.alu_v) r_sticky_v <= 1'b1;
      else if (bus.sticky_clr)              r_sticky_v <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Directed self-checking bench for alu_cmd_sequencer with an
//            adder ALU stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_cmd_sequencer_if #(.WIDTH(8)) bus ();

  alu_cmd_sequencer #(.DEPTH(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ALU stub: F = A+B, carry out, signed overflow, zero.
  logic [8:0] sum;
  assign sum       = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_f = sum[7:0];
  assign bus.alu_c = sum[8];
  assign bus.alu_v = (bus.alu_a[7] == bus.alu_b[7]) && (sum[7] != bus.alu_a[7]);
  assign bus.alu_z = (sum[7:0] == 8'h00);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected {op, c, v, z, f} for the adder stub.
  function automatic logic [13:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [8:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b};
    v = (a[7] == b[7]) && (s[7] != a[7]);
    return {op, s[8], v, (s[7:0] == 8'h00), s[7:0]};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.res_op, bus.res_c, bus.res_v, bus.res_z, bus.res_f};
  endfunction

  // One command through an idle sequencer with exact cycle timing.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input bit clr_at_cap);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("early_res_valid", bus.res_valid, 0);
    check("busy_after_accept", bus.busy, 1);
    @(posedge clk); #1;
    check("alu_ab", {bus.alu_a, bus.alu_b}, {a, b});
    check("alu_sel", {bus.alu_s2, bus.alu_s1, bus.alu_s0}, op);
    if (clr_at_cap) bus.sticky_clr = 1'b1;
    @(posedge clk); #1;
    bus.sticky_clr = 1'b0;
    check("res_valid", bus.res_valid, 1);
    check("res", observed(), model(a, b, op));
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("res_valid_drop", bus.res_valid, 0);
    check("busy_done", bus.busy, 0);
  endtask

  logic [7:0]  va [6] = '{8'h10, 8'hF0, 8'h80, 8'h33, 8'h01, 8'h7F};
  logic [7:0]  vb [6] = '{8'h20, 8'h20, 8'hFF, 8'h44, 8'hFE, 8'h7F};
  logic [2:0]  vo [6] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111, 3'b010};
  logic [13:0] exp_q [$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int got;
    int cyc;
    int last_cyc;
    bit hs_cmd;
    bit hs_res;
    bit bad;

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.res_ready = 1'b0; bus.sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_s2, bus.alu_s1, bus.alu_s0}, 0);
    check("rst_sticky", bus.sticky_v, 0);

    run_cmd(8'h05, 8'h03, 3'b000, 1'b0);
    run_cmd(8'h7F, 8'h01, 3'b001, 1'b0);
    check("sticky_set", bus.sticky_v, 1);
    run_cmd(8'h80, 8'h80, 3'b010, 1'b1);
    check("sticky_set_wins", bus.sticky_v, 1);
    bus.sticky_clr = 1'b1;
    @(posedge clk); #1;
    bus.sticky_clr = 1'b0;
    check("sticky_cleared", bus.sticky_v, 0);
    run_cmd(8'hFF, 8'h01, 3'b100, 1'b0);
    check("sticky_no_v", bus.sticky_v, 0);

    // Fill: results stalled, commands pushed back-to-back.
    idx = 0;
    bus.cmd_a = va[0]; bus.cmd_b = vb[0]; bus.cmd_op = vo[0]; bus.cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      hs_cmd = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (hs_cmd) begin
        exp_q.push_back(model(va[idx], vb[idx], vo[idx]));
        idx++;
        if (idx < 6) begin
          bus.cmd_a = va[idx]; bus.cmd_b = vb[idx]; bus.cmd_op = vo[idx];
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
    check("fill_accepted", idx, 5);
    check("fill_cmd_ready", bus.cmd_ready, 0);
    for (int k = 0; k < 3; k++) begin
      check("stall_res", {bus.res_valid, observed()}, {1'b1, exp_q[0]});
      @(posedge clk); #1;
    end
    check("stall_still_full", bus.cmd_ready, 0);

    // Drain with res_ready held high; backlog keeps a 2-cycle cadence.
    bus.res_ready = 1'b1;
    got = 0; cyc = 0; last_cyc = 0;
    for (int k = 0; k < 60 && got < 6; k++) begin
      hs_cmd = bus.cmd_valid && bus.cmd_ready;
      hs_res = bus.res_valid && bus.res_ready;
      if (hs_res) begin
        if (exp_q.size() == 0) check("drain_extra", 1, 0);
        else check("drain_res", observed(), exp_q.pop_front());
        if (got > 0) check("drain_gap", cyc - last_cyc, 2);
        last_cyc = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs_cmd) begin
        exp_q.push_back(model(va[idx], vb[idx], vo[idx]));
        idx++;
        bus.cmd_valid = 1'b0;
      end
    end
    bus.res_ready = 1'b0;
    check("drain_count", got, 6);
    check("drain_busy", bus.busy, 0);
    check("drain_res_valid", bus.res_valid, 0);

    // Reset while holding a result with two commands queued.
    bus.cmd_a = 8'h11; bus.cmd_b = 8'h22; bus.cmd_op = 3'b001; bus.cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    check("pre_rst_hold", {bus.res_valid, bus.busy}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_alu", {bus.alu_a, bus.alu_b, bus.alu_s2, bus.alu_s1, bus.alu_s0}, 0);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bad = bad | bus.res_valid | bus.busy;
    end
    check("mid_rst_quiet", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
